// File: rtl/riscv_ifetch.sv
// riscv_ifetch -- instruction fetch front end.
//
// Issues one 32-bit fetch per accepted request at the address held in the
// external PC register. It tags each request with its PC and returns
// responses in order through a small FIFO to decode. A credit limit on
// (outstanding + buffered) <= DEPTH means that FIFO can never overflow.
//
// A redirect does three things:
//   - it flushes the FIFO;
//   - it blocks issue for that cycle;
//   - it marks every still-outstanding request as "discard", so the late
//     responses from the old path are dropped.
//
// Ports
//   clk, rstn                  clock, async active-low reset
//   pc_i / pc_next_o           PC register current value / next value
//   redirect_i, redirect_pc_i  single-cycle redirect and its target
//   imem_req_o, imem_addr_o    fetch request / address
//   imem_gnt_i                 request accepted this cycle
//   imem_rvalid_i, imem_rdata_i in-order fetch response
//   inst_valid_o, inst_ready_i decode handshake
//   inst_o, inst_pc_o          FIFO head instruction and its PC
//   misalign_o                 pc_i not word aligned; fetch stalls until redirect
module riscv_ifetch #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] pc_i,
    output logic [63:0] pc_next_o,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [63:0] inst_pc_o,
    output logic        misalign_o
);

    localparam int CW = $clog2(DEPTH + 1);   // counter width
    localparam int PW = $clog2(DEPTH);       // pointer width

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_ent_t;

    // Tag queue: PCs of accepted requests awaiting their response.
    logic [DEPTH-1:0][63:0] tag_q;
    logic [PW-1:0]          tag_wr, tag_rd;
    logic [CW-1:0]          outst;

    // Response FIFO toward decode.
    fetch_ent_t [DEPTH-1:0] fifo_q;
    logic [PW-1:0]          f_wr, f_rd;
    logic [CW-1:0]          f_cnt;

    // Responses still to arrive that belong to a flushed path.
    logic [CW-1:0]          discard;

    logic pc_aligned, credit, accept, rsp_drop, push, pop;

    // Pointer increment that also works for non power-of-two DEPTH.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign pc_aligned  = (pc_i[1:0] == 2'b00);
    assign misalign_o  = ~pc_aligned;
    assign credit      = ((CW+1)'(outst) + (CW+1)'(f_cnt)) < (CW+1)'(DEPTH);
    assign imem_addr_o = pc_i;
    // rstn gating keeps the request low for the whole reset interval.
    assign imem_req_o  = rstn & ~redirect_i & pc_aligned & credit;
    assign accept      = imem_req_o & imem_gnt_i;

    always_comb begin
        pc_next_o = pc_i;
        if (redirect_i)
            pc_next_o = redirect_pc_i;
        else if (accept)
            pc_next_o = pc_i + 64'd4;
    end

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    // A response in the redirect cycle is from the old path too.
    assign rsp_drop = imem_rvalid_i & (redirect_i | (discard != '0));
    assign push     = imem_rvalid_i & ~rsp_drop;

    // Masking with redirect_i stops decode from taking a wrong-path
    // instruction in the cycle the flush is requested.
    assign inst_valid_o = (f_cnt != '0) & ~redirect_i;
    assign pop          = inst_valid_o & inst_ready_i;
    assign inst_o       = fifo_q[f_rd].inst;
    assign inst_pc_o    = fifo_q[f_rd].pc;

    // Tag queue and outstanding count. A redirect does not touch it:
    // dropped responses still retire their tag in order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_q  <= '0;
            tag_wr <= '0;
            tag_rd <= '0;
            outst  <= '0;
        end else begin
            if (accept) begin
                tag_q[tag_wr] <= pc_i;
                tag_wr        <= ptr_inc(tag_wr);
            end
            if (imem_rvalid_i)
                tag_rd <= ptr_inc(tag_rd);
            case ({accept, imem_rvalid_i})
                2'b10:   outst <= outst + CW'(1);
                2'b01:   outst <= outst - CW'(1);
                default: outst <= outst;
            endcase
        end
    end

    // Discard counter. On redirect, every request not answered this cycle
    // is stale. This also covers a redirect while already discarding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            discard <= '0;
        else if (redirect_i)
            discard <= outst - CW'(imem_rvalid_i);
        else if (imem_rvalid_i && discard != '0)
            discard <= discard - CW'(1);
    end

    // Response FIFO. Push and pop in the same cycle leave the count alone,
    // including when the FIFO is full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_q <= '0;
            f_wr   <= '0;
            f_rd   <= '0;
            f_cnt  <= '0;
        end else if (redirect_i) begin
            f_wr  <= '0;
            f_rd  <= '0;
            f_cnt <= '0;
        end else begin
            if (push) begin
                fifo_q[f_wr] <= '{pc: tag_q[tag_rd], inst: imem_rdata_i};
                f_wr         <= ptr_inc(f_wr);
            end
            if (pop)
                f_rd <= ptr_inc(f_rd);
            case ({push, pop})
                2'b10:   f_cnt <= f_cnt + CW'(1);
                2'b01:   f_cnt <= f_cnt - CW'(1);
                default: f_cnt <= f_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_ifetch.sv
module tb_riscv_ifetch;

    logic        clk;
    logic        rstn;
    logic [63:0] pc;
    logic [63:0] pc_next;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        inst_valid;
    logic        ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        misalign;

    logic        hold;        // memory holds back its responses
    int          n_vec = 0;
    int          n_bad = 0;

    logic [63:0] mem_q[$];
    logic [63:0] grant_q[$];
    logic [63:0] acc_pc_q[$];
    logic [31:0] acc_inst_q[$];

    riscv_ifetch #(.DEPTH(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .pc_i          (pc),
        .pc_next_o     (pc_next),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (gnt),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .inst_valid_o  (inst_valid),
        .inst_ready_i  (ready),
        .inst_o        (inst),
        .inst_pc_o     (inst_pc),
        .misalign_o    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register
    always @(posedge clk or negedge rstn)
        if (!rstn) pc <= 64'h0;
        else       pc <= pc_next;

    // Memory: answers in order, one cycle after grant at the earliest.
    // The returned word is C0DE followed by the low address bits.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rvalid <= 1'b0;
            rdata  <= 32'h0;
            mem_q.delete();
        end else begin
            if (!hold && mem_q.size() > 0) begin
                rvalid <= 1'b1;
                rdata  <= {16'hC0DE, mem_q[0][15:0]};
                void'(mem_q.pop_front());
            end else begin
                rvalid <= 1'b0;
            end
            if (imem_req && gnt)
                mem_q.push_back(imem_addr);
        end
    end

    // Log grants and decode accepts mid-cycle.
    always @(negedge clk) begin
        if (rstn) begin
            if (imem_req && gnt)
                grant_q.push_back(imem_addr);
            if (inst_valid && ready) begin
                acc_pc_q.push_back(inst_pc);
                acc_inst_q.push_back(inst);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_logs();
        grant_q.delete();
        acc_pc_q.delete();
        acc_inst_q.delete();
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        ready       = 1'b0;
        gnt         = 1'b1;
        hold        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr_logs();
        rstn = 1'b1;
    endtask

    task automatic wait_acc(input int n);
        int c;
        c = 0;
        while (acc_pc_q.size() < n && c < 60) begin
            step();
            c++;
        end
        @(negedge clk);
        #1;
        chk("acc_timeout", 64'(acc_pc_q.size() >= n), 64'h1);
    endtask

    function automatic logic [63:0] g0();
        return (grant_q.size() > 0) ? grant_q[0] : 64'hDEAD_DEAD;
    endfunction

    function automatic logic [63:0] a0();
        return (acc_pc_q.size() > 0) ? acc_pc_q[0] : 64'hDEAD_DEAD;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rstn = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
        ready = 1'b0; gnt = 1'b1; hold = 1'b0;
        @(negedge clk);
        chk("rst_req",   64'(imem_req),   64'h0);
        chk("rst_valid", 64'(inst_valid), 64'h0);
        chk("rst_inst",  64'(inst),       64'h0);
        chk("rst_ipc",   inst_pc,         64'h0);
        chk("rst_mis",   64'(misalign),   64'h0);

        // Streaming: addresses 0,4,8,C in order
        do_reset();
        ready = 1'b1;
        wait_acc(4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s_gnt%0d", i),  (grant_q.size() > i) ? grant_q[i] : 64'hDEAD, 64'(i * 4));
            chk($sformatf("s_pc%0d", i),   (acc_pc_q.size() > i) ? acc_pc_q[i] : 64'hDEAD, 64'(i * 4));
            chk($sformatf("s_inst%0d", i), (acc_inst_q.size() > i) ? 64'(acc_inst_q[i]) : 64'hDEAD,
                64'(32'hC0DE0000 + 32'(i * 4)));
        end

        // Backpressure: two grants fill the credit, fetch stalls
        do_reset();
        repeat (8) step();
        @(negedge clk);
        chk("bp_ngnt",  64'(grant_q.size()), 64'd2);
        chk("bp_req",   64'(imem_req),       64'h0);
        chk("bp_pcnx",  pc_next,             64'h8);
        chk("bp_valid", 64'(inst_valid),     64'h1);
        chk("bp_ipc",   inst_pc,             64'h0);
        chk("bp_inst",  64'(inst),           64'hC0DE0000);
        step();
        @(negedge clk);
        chk("bp_hold_ipc", inst_pc, 64'h0);
        step();
        clr_logs();
        ready = 1'b1;
        wait_acc(2);
        chk("bp_pop0", a0(), 64'h0);
        chk("bp_pop1", (acc_pc_q.size() > 1) ? acc_pc_q[1] : 64'hDEAD, 64'h4);
        chk("bp_resume", g0(), 64'h8);

        // Redirect with two outstanding, late responses dropped
        do_reset();
        hold  = 1'b1;
        ready = 1'b1;
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        @(negedge clk);
        chk("rd_req",   64'(imem_req),   64'h0);
        chk("rd_pcnx",  pc_next,         64'h100);
        chk("rd_valid", 64'(inst_valid), 64'h0);
        step();
        redirect = 1'b0;
        hold     = 1'b0;
        clr_logs();
        wait_acc(1);
        chk("rd_ipc",  a0(), 64'h100);
        chk("rd_inst", (acc_inst_q.size() > 0) ? 64'(acc_inst_q[0]) : 64'hDEAD, 64'hC0DE0100);
        chk("rd_gnt",  g0(), 64'h100);

        // No grant: request held, address and next PC unchanged
        do_reset();
        gnt   = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("ng_req%0d", i),  64'(imem_req), 64'h1);
            chk($sformatf("ng_addr%0d", i), imem_addr,     64'h0);
            chk($sformatf("ng_pcnx%0d", i), pc_next,       64'h0);
            step();
        end
        gnt = 1'b1;
        @(negedge clk);
        chk("ng_pcnx_go", pc_next, 64'h4);

        // Misaligned redirect halts fetch; aligned redirect resumes
        do_reset();
        ready = 1'b1;
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 64'h102;
        step();
        redirect = 1'b0;
        clr_logs();
        @(negedge clk);
        chk("ma_mis",  64'(misalign), 64'h1);
        chk("ma_req",  64'(imem_req), 64'h0);
        chk("ma_pcnx", pc_next,       64'h102);
        repeat (5) step();
        chk("ma_ngnt", 64'(grant_q.size()),  64'h0);
        chk("ma_nacc", 64'(acc_pc_q.size()), 64'h0);
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        step();
        redirect = 1'b0;
        wait_acc(1);
        chk("ma_ipc", a0(), 64'h200);
        chk("ma_gnt", g0(), 64'h200);
        chk("ma_mis_clr", 64'(misalign), 64'h0);

        // Asynchronous reset with a full FIFO
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 64'h300;
        step();
        redirect = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("ar_valid_pre", 64'(inst_valid), 64'h1);
        chk("ar_ipc_pre",   inst_pc,         64'h300);
        step();
        rstn = 1'b0;
        #1;
        chk("ar_valid", 64'(inst_valid), 64'h0);
        chk("ar_inst",  64'(inst),       64'h0);
        chk("ar_ipc",   inst_pc,         64'h0);
        chk("ar_req",   64'(imem_req),   64'h0);
        step();
        clr_logs();
        rstn  = 1'b1;
        ready = 1'b1;
        wait_acc(1);
        chk("ar_first_pc",   a0(), 64'h0);
        chk("ar_first_inst", (acc_inst_q.size() > 0) ? 64'(acc_inst_q[0]) : 64'hDEAD, 64'hC0DE0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
